cdnsdru_usb4_message_bus_link_eval_tx_writer: RTL and testbench
===============================================================

// Module: cdnsdru_usb4_message_bus_link_eval_tx_writer
// PURPOSE
//  Downstream MB TX stage for RX link-eval status. Takes the eval_legacy/eval_g67/fom write requests and status0..3 bytes from the link-eval status-reg controller.
//  Frames them as PIPE P2M message-bus writes (uncommitted/committed) and waits for the MAC write_ack.
//  Returns prio_tx_writes_done_le[2:0] to the requester. Sits between the link-eval controller and the shared P2M bus mux.
// PARAMETERS
//  ADDR_STAT0   12'h00A  MAC addr, RxLinkEvalStatus0 (FoM)
//  ADDR_STAT1   12'h00B  MAC addr, RxLinkEvalStatus1 (legacy dir change)
//  ADDR_STAT2   12'h00C  MAC addr, RxLinkEvalStatus2 (g67 dir change low)
//  ADDR_STAT3   12'h00D  MAC addr, RxLinkEvalStatus3 (g67 dir change high)
//  ACK_TIMEOUT  8'd255   max cycles in WAIT_ACK before forced completion
// PORTS
//  pipe_mac2phy_clk      in   1  MB clock
//  pipe_mac2phy_rstn     in   1  async active-low reset
//  cdb_reset             in   1  MB soft reset, sync, active-high
//  cdb_ctrl_reset        in   1  MB controller soft reset, sync, active-high
//  fom_tx_write          in   1  level request: write status0
//  eval_legacy_tx_write  in   1  level request: write status1
//  eval_g67_tx_write     in   1  level request: write status2 then status3
//  rx_link_eval_status0..3  in  8 each  payload bytes
//  p2m_bus_gnt           in   1  P2M bus mux grant
//  m2p_write_ack         in   1  1-cycle pulse, write_ack decoded from M2P
//  p2m_bus_req           out  1  P2M bus request
//  mb_p2m_data           out  8  P2M message-bus byte (8'h00 = NOP)
//  prio_tx_writes_done_le out 3 1-cycle done: [0]=fom [1]=legacy [2]=g67
//  ack_timeout_err       out  1  sticky: a write completed by timeout
// BEHAVIOUR
//  Clock pipe_mac2phy_clk. Reset pipe_mac2phy_rstn: asynchronous, active-low.
//  Soft reset = cdb_reset|cdb_ctrl_reset: synchronous, same effect as rstn. Clears the FSM, counters and ack_timeout_err.
//  Reset values: p2m_bus_req=0, mb_p2m_data=8'h00, done=3'b000, ack_timeout_err=0, state=IDLE.
//  IDLE: select a request by priority fom > legacy > g67.
//   - Latch the sel one-hot, addresses and payload bytes into shadow regs.
//   - Go to REQ_BUS. Payload is frozen from this point to DONE.
//  REQ_BUS: p2m_bus_req=1. When gnt is sampled high, go to SEND on the next cycle. Wait indefinitely otherwise.
//  SEND: one byte per cycle, p2m_bus_req held 1. beat_cnt runs 0..2 (fom/legacy) or 0..5 (g67).
//   - beat0 {cmd,addr[11:8]}, beat1 addr[7:0], beat2 data.
//   - cmd = 4'b0010 write_committed on the final write. cmd = 4'b0001 write_uncommitted on the g67 status2 write.
//  Cycle after the last beat: mb_p2m_data=00 and p2m_bus_req=0. Go to WAIT_ACK.
//  WAIT_ACK: tmo_cnt counts from 0.
//   - On m2p_write_ack, go to DONE.
//   - On tmo_cnt==ACK_TIMEOUT, set ack_timeout_err and go to DONE.
//   - If ack and timeout fall on the same cycle, ack wins and no error is flagged.
//  DONE: pulse done[sel] for exactly 1 cycle, then go to IDLE.
//   - Upstream drops its request in response to done, so the block never re-arms on a stale level.
//   - IDLE ignores requests during the cycle after DONE.
//  m2p_write_ack outside WAIT_ACK: ignored, no state change.
//  Request deasserted mid-transaction: the frame still completes and done still pulses. A frame is never truncated.
//  Latency, no contention: req@T -> req_bus@T+1 -> gnt@T+1 -> beat0@T+2 -> last beat@T+4 (g67: @T+7).
// STRUCTURE
//  Shared package: MB cmd encodings (NOP/WR_UNC/WR_COM/WRITE_ACK) and the FSM state enum.
//  One sub-module: cdnsdru_usb4_mb_p2m_write_framer. It takes {cmd,addr,data} plus start, and emits 3 beats and last.
//  Top holds the arbiter, the FSM (IDLE/REQ_BUS/SEND/WAIT_ACK/DONE), the ack timeout and the shadow regs.
// TESTING
//  fom_tx_write=1, status0=8'h5A, gnt=1, ack 4 cycles after last beat
//   -> P2M bytes 20,0A,5A; done=3'b001 for 1 cycle; then idle.
//  eval_g67_tx_write=1, status2=8'h12, status3=8'h34
//   -> bytes 10,0C,12,20,0D,34 on consecutive cycles; done=3'b100 after ack.
//  fom and legacy asserted together
//   -> fom frame first, done[0]; legacy frame next, done[1].
//  legacy request, gnt held low 10 cycles
//   -> p2m_bus_req=1 throughout and data=00; beat0=8'h20 on the cycle after gnt rises.
//  No ack after the frame
//   -> done[1] pulses ACK_TIMEOUT+1 cycles later; ack_timeout_err=1 until cdb_ctrl_reset.
//  pipe_mac2phy_rstn low during beat1
//   -> bus_req=0 and data=00 immediately; no done pulse; a new request starts a clean frame.

Source files
------------

// File: rtl/cdnsdru_usb4_message_bus_link_eval_tx_writer_pkg.sv
// Shared definitions for the link-eval message-bus TX writer: MB command
// encodings, FSM states and the request one-hot selects.
package cdnsdru_usb4_message_bus_link_eval_tx_writer_pkg;

  typedef enum logic [3:0] {
    MB_NOP       = 4'b0000,
    MB_WR_UNC    = 4'b0001,
    MB_WR_COM    = 4'b0010,
    MB_WRITE_ACK = 4'b0011
  } mb_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_BUS,
    ST_SEND,
    ST_WAIT_ACK,
    ST_DONE
  } tx_state_e;

  // Bit positions match prio_tx_writes_done_le
  localparam logic [2:0] SEL_FOM    = 3'b001;
  localparam logic [2:0] SEL_LEGACY = 3'b010;
  localparam logic [2:0] SEL_G67    = 3'b100;

endpackage

// File: rtl/cdnsdru_usb4_mb_p2m_write_framer.sv
// Serialises one message-bus write into three P2M beats:
// {cmd,addr[11:8]}, addr[7:0], data. Beat 0 is emitted in the start cycle.
module cdnsdru_usb4_mb_p2m_write_framer (
  input  logic        pipe_mac2phy_clk,
  input  logic        pipe_mac2phy_rstn,
  input  logic        soft_rst,
  input  logic        start,
  input  logic [3:0]  cmd,
  input  logic [11:0] addr,
  input  logic [7:0]  data,
  output logic        beat_valid,
  output logic [7:0]  beat,
  output logic        last
);

  logic       busy;
  logic [1:0] idx;
  logic [1:0] cur_idx;

  assign cur_idx    = start ? 2'd0 : idx;
  assign beat_valid = start | busy;
  assign last       = beat_valid && (cur_idx == 2'd2);

  always_comb begin
    beat = 8'h00;
    if (beat_valid) begin
      case (cur_idx)
        2'd0:    beat = {cmd, addr[11:8]};
        2'd1:    beat = addr[7:0];
        default: beat = data;
      endcase
    end
  end

  always_ff @(posedge pipe_mac2phy_clk or negedge pipe_mac2phy_rstn) begin
    if (!pipe_mac2phy_rstn) begin
      busy <= 1'b0;
      idx  <= 2'd0;
    end else if (soft_rst) begin
      busy <= 1'b0;
      idx  <= 2'd0;
    end else if (beat_valid) begin
      if (cur_idx == 2'd2) begin
        busy <= 1'b0;
        idx  <= 2'd0;
      end else begin
        busy <= 1'b1;
        idx  <= cur_idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/cdnsdru_usb4_message_bus_link_eval_tx_writer.sv
// Link-eval status writer: arbitrates fom/legacy/g67 requests, frames them as
// P2M message-bus writes, waits for write_ack (with timeout) and pulses done.
module cdnsdru_usb4_message_bus_link_eval_tx_writer
  import cdnsdru_usb4_message_bus_link_eval_tx_writer_pkg::*;
#(
  parameter logic [11:0] ADDR_STAT0  = 12'h00A,
  parameter logic [11:0] ADDR_STAT1  = 12'h00B,
  parameter logic [11:0] ADDR_STAT2  = 12'h00C,
  parameter logic [11:0] ADDR_STAT3  = 12'h00D,
  parameter logic [7:0]  ACK_TIMEOUT = 8'd255
) (
  input  logic       pipe_mac2phy_clk,
  input  logic       pipe_mac2phy_rstn,
  input  logic       cdb_reset,
  input  logic       cdb_ctrl_reset,
  input  logic       fom_tx_write,
  input  logic       eval_legacy_tx_write,
  input  logic       eval_g67_tx_write,
  input  logic [7:0] rx_link_eval_status0,
  input  logic [7:0] rx_link_eval_status1,
  input  logic [7:0] rx_link_eval_status2,
  input  logic [7:0] rx_link_eval_status3,
  input  logic       p2m_bus_gnt,
  input  logic       m2p_write_ack,
  output logic       p2m_bus_req,
  output logic [7:0] mb_p2m_data,
  output logic [2:0] prio_tx_writes_done_le,
  output logic       ack_timeout_err
);

  tx_state_e   state;
  tx_state_e   state_nxt;
  logic        soft_rst;
  logic [2:0]  arb_sel;
  logic        accept;
  logic [2:0]  sel_q;
  logic        two_wr_q;
  logic [3:0]  cmd0_q;
  logic [11:0] addr0_q;
  logic [11:0] addr1_q;
  logic [7:0]  data0_q;
  logic [7:0]  data1_q;
  logic [2:0]  beat_cnt;
  logic [7:0]  tmo_cnt;
  logic        tmo_hit;
  logic        hold_off;
  logic        second_wr;
  logic        frame_start;
  logic        frame_valid;
  logic        frame_last;
  logic [7:0]  frame_beat;
  logic [3:0]  frame_cmd;
  logic [11:0] frame_addr;
  logic [7:0]  frame_data;

  assign soft_rst = cdb_reset | cdb_ctrl_reset;

  always_comb begin
    arb_sel = 3'b000;
    if (fom_tx_write)              arb_sel = SEL_FOM;
    else if (eval_legacy_tx_write) arb_sel = SEL_LEGACY;
    else if (eval_g67_tx_write)    arb_sel = SEL_G67;
  end

  // hold_off masks the IDLE cycle right after DONE so a stale level is not re-armed
  assign accept      = (state == ST_IDLE) && !hold_off && (arb_sel != 3'b000);
  assign second_wr   = (beat_cnt >= 3'd3);
  assign frame_start = (state == ST_SEND) && ((beat_cnt == 3'd0) || (beat_cnt == 3'd3));
  assign frame_cmd   = second_wr ? MB_WR_COM : cmd0_q;
  assign frame_addr  = second_wr ? addr1_q : addr0_q;
  assign frame_data  = second_wr ? data1_q : data0_q;
  assign tmo_hit     = (tmo_cnt == ACK_TIMEOUT);

  cdnsdru_usb4_mb_p2m_write_framer u_framer (
    .pipe_mac2phy_clk  (pipe_mac2phy_clk),
    .pipe_mac2phy_rstn (pipe_mac2phy_rstn),
    .soft_rst          (soft_rst),
    .start             (frame_start),
    .cmd               (frame_cmd),
    .addr              (frame_addr),
    .data              (frame_data),
    .beat_valid        (frame_valid),
    .beat              (frame_beat),
    .last              (frame_last)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (accept) state_nxt = ST_REQ_BUS;
      ST_REQ_BUS:  if (p2m_bus_gnt) state_nxt = ST_SEND;
      ST_SEND:     if (frame_last && (!two_wr_q || second_wr)) state_nxt = ST_WAIT_ACK;
      ST_WAIT_ACK: if (m2p_write_ack || tmo_hit) state_nxt = ST_DONE;
      ST_DONE:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge pipe_mac2phy_clk or negedge pipe_mac2phy_rstn) begin
    if (!pipe_mac2phy_rstn) begin
      state    <= ST_IDLE;
      hold_off <= 1'b0;
      beat_cnt <= 3'd0;
      tmo_cnt  <= 8'd0;
    end else if (soft_rst) begin
      state    <= ST_IDLE;
      hold_off <= 1'b0;
      beat_cnt <= 3'd0;
      tmo_cnt  <= 8'd0;
    end else begin
      state    <= state_nxt;
      hold_off <= (state == ST_DONE);
      beat_cnt <= (state == ST_SEND) ? beat_cnt + 3'd1 : 3'd0;
      tmo_cnt  <= (state == ST_WAIT_ACK) ? tmo_cnt + 8'd1 : 8'd0;
    end
  end

  // Shadow copy of the selected write; frozen until the next accept
  always_ff @(posedge pipe_mac2phy_clk or negedge pipe_mac2phy_rstn) begin
    if (!pipe_mac2phy_rstn) begin
      sel_q    <= 3'b000;
      two_wr_q <= 1'b0;
      cmd0_q   <= 4'b0000;
      addr0_q  <= 12'h000;
      addr1_q  <= 12'h000;
      data0_q  <= 8'h00;
      data1_q  <= 8'h00;
    end else if (soft_rst) begin
      sel_q    <= 3'b000;
      two_wr_q <= 1'b0;
      cmd0_q   <= 4'b0000;
      addr0_q  <= 12'h000;
      addr1_q  <= 12'h000;
      data0_q  <= 8'h00;
      data1_q  <= 8'h00;
    end else if (accept) begin
      sel_q <= arb_sel;
      case (arb_sel)
        SEL_FOM: begin
          two_wr_q <= 1'b0;
          cmd0_q   <= MB_WR_COM;
          addr0_q  <= ADDR_STAT0;
          data0_q  <= rx_link_eval_status0;
        end
        SEL_LEGACY: begin
          two_wr_q <= 1'b0;
          cmd0_q   <= MB_WR_COM;
          addr0_q  <= ADDR_STAT1;
          data0_q  <= rx_link_eval_status1;
        end
        default: begin
          two_wr_q <= 1'b1;
          cmd0_q   <= MB_WR_UNC;
          addr0_q  <= ADDR_STAT2;
          data0_q  <= rx_link_eval_status2;
          addr1_q  <= ADDR_STAT3;
          data1_q  <= rx_link_eval_status3;
        end
      endcase
    end
  end

  // A same-cycle ack beats the timeout, so only flag when no ack arrived
  always_ff @(posedge pipe_mac2phy_clk or negedge pipe_mac2phy_rstn) begin
    if (!pipe_mac2phy_rstn) begin
      ack_timeout_err <= 1'b0;
    end else if (soft_rst) begin
      ack_timeout_err <= 1'b0;
    end else if ((state == ST_WAIT_ACK) && tmo_hit && !m2p_write_ack) begin
      ack_timeout_err <= 1'b1;
    end
  end

  always_comb begin
    p2m_bus_req            = (state == ST_REQ_BUS) || (state == ST_SEND);
    mb_p2m_data            = ((state == ST_SEND) && frame_valid) ? frame_beat : 8'h00;
    prio_tx_writes_done_le = (state == ST_DONE) ? sel_q : 3'b000;
  end

endmodule

// File: tb/tb_cdnsdru_usb4_message_bus_link_eval_tx_writer.sv
// Self-checking bench: directed and random link-eval write requests compared
// against a byte-list model of the expected P2M frames and done/ack timing.
module tb_cdnsdru_usb4_message_bus_link_eval_tx_writer;

  logic       clk;
  logic       rstn;
  logic       cdb_reset;
  logic       cdb_ctrl_reset;
  logic [2:0] req_lvl;
  logic [7:0] st0, st1, st2, st3;
  logic       gnt;
  logic       ack;
  logic       bus_req;
  logic [7:0] p2m_data;
  logic [2:0] done;
  logic       tmo_err;

  int n_checks = 0;
  int n_errors = 0;
  logic err_model = 1'b0;
  logic [7:0] exp_q[$];

  cdnsdru_usb4_message_bus_link_eval_tx_writer dut (
    .pipe_mac2phy_clk       (clk),
    .pipe_mac2phy_rstn      (rstn),
    .cdb_reset              (cdb_reset),
    .cdb_ctrl_reset         (cdb_ctrl_reset),
    .fom_tx_write           (req_lvl[0]),
    .eval_legacy_tx_write   (req_lvl[1]),
    .eval_g67_tx_write      (req_lvl[2]),
    .rx_link_eval_status0   (st0),
    .rx_link_eval_status1   (st1),
    .rx_link_eval_status2   (st2),
    .rx_link_eval_status3   (st3),
    .p2m_bus_gnt            (gnt),
    .m2p_write_ack          (ack),
    .p2m_bus_req            (bus_req),
    .mb_p2m_data            (p2m_data),
    .prio_tx_writes_done_le (done),
    .ack_timeout_err        (tmo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_req"}, 8'(bus_req), 8'h00);
    checkOutput({tag, "_data"}, p2m_data, 8'h00);
    checkOutput({tag, "_done"}, 8'(done), 8'h00);
  endtask

  task automatic applyStimulus(input logic [2:0] reqs);
    req_lvl = reqs;
  endtask

  function automatic logic [2:0] pick(input logic [2:0] r);
    if (r[0]) return 3'b001;
    if (r[1]) return 3'b010;
    if (r[2]) return 3'b100;
    return 3'b000;
  endfunction

  function automatic void push_write(input logic [3:0] cmd, input logic [11:0] addr, input logic [7:0] d);
    exp_q.push_back({cmd, addr[11:8]});
    exp_q.push_back(addr[7:0]);
    exp_q.push_back(d);
  endfunction

  // One full transaction from an accepting IDLE cycle to the cycle after the
  // hold-off cycle; ack_dly > 255 means no ack is ever sent.
  task automatic run_frame(input logic [2:0] reqs, input int gnt_dly, input int ack_dly,
                           input bit drop_early, input string tag);
    logic [2:0] who;
    who = pick(reqs);
    exp_q.delete();
    case (who)
      3'b001:  push_write(4'h2, 12'h00A, st0);
      3'b010:  push_write(4'h2, 12'h00B, st1);
      default: begin
        push_write(4'h1, 12'h00C, st2);
        push_write(4'h2, 12'h00D, st3);
      end
    endcase
    applyStimulus(reqs);
    gnt = 1'b0;
    tick();
    checkOutput({tag, "_reqbus"}, 8'(bus_req), 8'h01);
    checkOutput({tag, "_reqbus_data"}, p2m_data, 8'h00);
    if (drop_early) applyStimulus(3'b000);
    st0 = 8'($urandom); st1 = 8'($urandom); st2 = 8'($urandom); st3 = 8'($urandom);
    for (int i = 0; i < gnt_dly; i++) begin
      tick();
      checkOutput($sformatf("%s_gntwait%0d_req", tag, i), 8'(bus_req), 8'h01);
      checkOutput($sformatf("%s_gntwait%0d_data", tag, i), p2m_data, 8'h00);
    end
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      checkOutput($sformatf("%s_beat%0d_req", tag, k), 8'(bus_req), 8'h01);
      checkOutput($sformatf("%s_beat%0d", tag, k), p2m_data, exp_q[k]);
      tick();
    end
    checkIdle({tag, "_postframe"});
    for (int j = 0; j <= 255; j++) begin
      if (j > 0) checkOutput($sformatf("%s_wait%0d_done", tag, j), 8'(done), 8'h00);
      if (j == ack_dly) ack = 1'b1;
      tick();
      ack = 1'b0;
      if (j == ack_dly) break;
    end
    if (ack_dly > 255) err_model = 1'b1;
    checkOutput({tag, "_done"}, 8'(done), 8'(who));
    checkOutput({tag, "_tmo_err"}, 8'(tmo_err), 8'(err_model));
    applyStimulus(req_lvl & ~who);
    tick();
    checkOutput({tag, "_done_1cyc"}, 8'(done), 8'h00);
    tick();
    checkOutput({tag, "_holdoff_req"}, 8'(bus_req), 8'h00);
  endtask

  initial begin
    logic [2:0] reqs;
    bit         drop;
    rstn = 1'b0; cdb_reset = 1'b0; cdb_ctrl_reset = 1'b0;
    req_lvl = 3'b000; gnt = 1'b0; ack = 1'b0;
    st0 = 8'h00; st1 = 8'h00; st2 = 8'h00; st3 = 8'h00;
    repeat (2) tick();
    checkIdle("reset");
    checkOutput("reset_err", 8'(tmo_err), 8'h00);
    rstn = 1'b1;
    tick();

    st0 = 8'h5A;
    run_frame(3'b001, 0, 3, 1'b0, "fom");

    st2 = 8'h12; st3 = 8'h34;
    run_frame(3'b100, 0, 2, 1'b0, "g67");

    run_frame(3'b011, 0, 1, 1'b0, "prio_fom");
    run_frame(3'b010, 0, 1, 1'b0, "prio_legacy");

    run_frame(3'b010, 10, 0, 1'b0, "gnt_late");
    run_frame(3'b100, 1, 4, 1'b1, "drop_mid");

    run_frame(3'b010, 0, 255, 1'b0, "ack_at_limit");
    run_frame(3'b010, 0, 1000, 1'b0, "timeout");
    repeat (3) tick();
    checkOutput("err_sticky", 8'(tmo_err), 8'h01);
    run_frame(3'b001, 0, 2, 1'b0, "after_tmo");
    cdb_ctrl_reset = 1'b1;
    tick();
    cdb_ctrl_reset = 1'b0;
    err_model = 1'b0;
    checkOutput("err_cleared", 8'(tmo_err), 8'h00);

    ack = 1'b1;
    tick();
    ack = 1'b0;
    for (int i = 0; i < 3; i++) checkIdle($sformatf("stray_ack%0d", i));
    tick();

    // Async reset in the middle of a legacy frame
    applyStimulus(3'b010);
    tick();
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    checkOutput("rst_beat0", p2m_data, 8'h20);
    tick();
    checkOutput("rst_beat1", p2m_data, 8'h0B);
    rstn = 1'b0;
    #1;
    checkIdle("rst_immediate");
    applyStimulus(3'b000);
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkIdle($sformatf("rst_quiet%0d", i));
    end
    run_frame(3'b010, 0, 2, 1'b0, "after_rst");

    for (int it = 0; it < 10; it++) begin
      reqs = 3'($urandom_range(1, 7));
      st0 = 8'($urandom); st1 = 8'($urandom); st2 = 8'($urandom); st3 = 8'($urandom);
      while (reqs != 3'b000) begin
        drop = ($urandom_range(0, 3) == 0);
        run_frame(reqs, int'($urandom_range(0, 4)), int'($urandom_range(0, 12)), drop,
                  $sformatf("rand%0d", it));
        reqs = drop ? 3'b000 : (reqs & ~pick(reqs));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
